term_writer: RTL and testbench



---
 rtl/term_pkg.sv | 44 ++++
 rtl/term_writer.sv | 177 +++++++++++++++++
 tb/tb_term_writer.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/term_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : term_pkg
//  Description : Shared geometry, character codes, writer state encoding and
//                the physical-row wrap helper for the character display.
//  Revision    : 1.0  initial release
// ============================================================================
package term_pkg;

  localparam int COLS  = 80;
  localparam int ROWS  = 24;
  localparam int COL_W = 7;
  localparam int ROW_W = 5;

  // Typed limits so index comparisons stay width-exact
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0] COL_END  = COL_W'(COLS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(ROWS);

  localparam logic [7:0] CHAR_SPACE     = 8'h20;
  localparam logic [7:0] CHAR_BS        = 8'h08;
  localparam logic [7:0] CHAR_LF        = 8'h0A;
  localparam logic [7:0] CHAR_CR        = 8'h0D;
  localparam logic [7:0] CHAR_PRINT_MIN = 8'h20;
  localparam logic [7:0] CHAR_PRINT_MAX = 8'h7E;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // (a + b) mod ROWS for operands already in 0..ROWS-1: one conditional subtract
  function automatic logic [ROW_W-1:0] row_wrap(input logic [ROW_W-1:0] a,
                                                input logic [ROW_W-1:0] b);
    logic [ROW_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (ROW_W+1)'(ROWS)) sum = sum - (ROW_W+1)'(ROWS);
    return sum[ROW_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/term_writer.sv
`default_nettype none
// ============================================================================
//  Module      : term_writer
//  Description : Terminal write controller. Accepts a host byte stream,
//                tracks the cursor, writes printable characters to VRAM and
//                clears rows; scrolling rotates the physical top-row offset.
//  Revision    : 1.0  initial release
// ============================================================================
module term_writer
  import term_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [7:0]       wr_data,
  output logic [ROW_W-1:0] scroll_top,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col
);

  state_t           state, state_n;
  logic             wr_en_n;
  logic [ROW_W-1:0] wr_row_n, scroll_n, crow_n;
  logic [COL_W-1:0] wr_col_n, ccol_n;
  logic [7:0]       wr_data_n;

  // Sweep counters: INIT walks (cnt_row, cnt_col) over the whole screen and
  // ends when cnt_row reaches ROWS; CLEAR walks cnt_col over clr_row and ends
  // when cnt_col reaches COLS. One extra counter value gives the idle cycle
  // between the last write and in_ready rising.
  logic [ROW_W-1:0] cnt_row, cnt_row_n;
  logic [COL_W-1:0] cnt_col, cnt_col_n;
  logic [ROW_W-1:0] clr_row, clr_row_n;

  logic             accept;
  logic             printable;
  logic             advance;
  logic [ROW_W-1:0] phys_row;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid & in_ready;
  assign phys_row = row_wrap(cursor_row, scroll_top);

  // Register bank: FSM state, registered VRAM port, cursor and sweep counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_INIT;
      wr_en      <= 1'b0;
      wr_row     <= '0;
      wr_col     <= '0;
      wr_data    <= CHAR_SPACE;
      scroll_top <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      cnt_row    <= '0;
      cnt_col    <= '0;
      clr_row    <= '0;
    end else begin
      state      <= state_n;
      wr_en      <= wr_en_n;
      wr_row     <= wr_row_n;
      wr_col     <= wr_col_n;
      wr_data    <= wr_data_n;
      scroll_top <= scroll_n;
      cursor_row <= crow_n;
      cursor_col <= ccol_n;
      cnt_row    <= cnt_row_n;
      cnt_col    <= cnt_col_n;
      clr_row    <= clr_row_n;
    end
  end

  // Next-state, cursor movement and VRAM write selection
  always_comb begin
    state_n   = state;
    wr_en_n   = 1'b0;
    wr_row_n  = wr_row;
    wr_col_n  = wr_col;
    wr_data_n = wr_data;
    scroll_n  = scroll_top;
    crow_n    = cursor_row;
    ccol_n    = cursor_col;
    cnt_row_n = cnt_row;
    cnt_col_n = cnt_col;
    clr_row_n = clr_row;
    printable = (in_data >= CHAR_PRINT_MIN) && (in_data <= CHAR_PRINT_MAX);
    advance   = 1'b0;

    case (state)
      ST_INIT: begin
        if (cnt_row == ROW_END) begin
          state_n   = ST_IDLE;
          cnt_row_n = '0;
          cnt_col_n = '0;
        end else begin
          wr_en_n   = 1'b1;
          wr_row_n  = cnt_row;
          wr_col_n  = cnt_col;
          wr_data_n = CHAR_SPACE;
          if (cnt_col == COL_LAST) begin
            cnt_col_n = '0;
            cnt_row_n = cnt_row + ROW_W'(1);
          end else begin
            cnt_col_n = cnt_col + COL_W'(1);
          end
        end
      end

      ST_CLEAR: begin
        if (cnt_col == COL_END) begin
          state_n   = ST_IDLE;
          cnt_col_n = '0;
        end else begin
          wr_en_n   = 1'b1;
          wr_row_n  = clr_row;
          wr_col_n  = cnt_col;
          wr_data_n = CHAR_SPACE;
          cnt_col_n = cnt_col + COL_W'(1);
        end
      end

      ST_IDLE: begin
        if (accept) begin
          if (printable) begin
            wr_en_n   = 1'b1;
            wr_row_n  = phys_row;
            wr_col_n  = cursor_col;
            wr_data_n = in_data;
            if (cursor_col == COL_LAST) begin
              ccol_n  = '0;
              advance = 1'b1;
            end else begin
              ccol_n = cursor_col + COL_W'(1);
            end
          end else if (in_data == CHAR_CR) begin
            ccol_n = '0;
          end else if (in_data == CHAR_LF) begin
            advance = 1'b1;
          end else if (in_data == CHAR_BS) begin
            if (cursor_col != '0) ccol_n = cursor_col - COL_W'(1);
          end

          if (advance) begin
            if (cursor_row != ROW_LAST) begin
              crow_n = cursor_row + ROW_W'(1);
            end else begin
              // Old top row becomes the new bottom row and must be blanked
              scroll_n  = row_wrap(scroll_top, ROW_W'(1));
              clr_row_n = scroll_top;
              state_n   = ST_CLEAR;
              if (printable) begin
                // Port is busy with the character; clearing starts next cycle
                cnt_col_n = '0;
              end else begin
                // Port is free, so column 0 is cleared right away
                wr_en_n   = 1'b1;
                wr_row_n  = scroll_top;
                wr_col_n  = '0;
                wr_data_n = CHAR_SPACE;
                cnt_col_n = COL_W'(1);
              end
            end
          end
        end
      end

      default: state_n = ST_INIT;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_term_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_term_writer
//  Description : Directed self-checking bench for term_writer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_term_writer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wr_en;
  logic [4:0] wr_row;
  logic [6:0] wr_col;
  logic [7:0] wr_data;
  logic [4:0] scroll_top;
  logic [4:0] cursor_row;
  logic [6:0] cursor_col;

  int tests = 0;
  int fails = 0;

  term_writer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_data    (wr_data),
    .scroll_top (scroll_top),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one byte, wait (bounded) for acceptance, return at cycle N+1
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!in_ready) begin
      fails++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    tests++;
    if (wr_en !== 1'b0 || wr_row !== 5'd0 || wr_col !== 7'd0 || wr_data !== 8'h20) begin
      fails++;
      $display("FAIL reset_wr: en=%0b row=%0d col=%0d data=%h, required 0 0 0 20", wr_en, wr_row, wr_col, wr_data);
    end
    tests++;
    if (scroll_top !== 5'd0 || cursor_row !== 5'd0 || cursor_col !== 7'd0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_cursor: top=%0d row=%0d col=%0d ready=%0b, required 0 0 0 0", scroll_top, cursor_row, cursor_col, in_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_init();
    int bad;
    bad = 0;
    for (int k = 1; k <= 1920; k++) begin
      @(negedge clk);
      if (bad == 0 && (wr_en !== 1'b1 || in_ready !== 1'b0 || wr_data !== 8'h20 ||
                       wr_row !== 5'((k-1)/80) || wr_col !== 7'((k-1)%80))) begin
        bad = k;
        $display("FAIL init_seq: cycle %0d en=%0b ready=%0b row=%0d col=%0d data=%h, required 1 0 %0d %0d 20",
                 k, wr_en, in_ready, wr_row, wr_col, wr_data, (k-1)/80, (k-1)%80);
      end
    end
    tests++;
    if (bad != 0) fails++;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || wr_en !== 1'b0) begin
      fails++;
      $display("FAIL init_done: cycle 1921 ready=%0b en=%0b, required 1 0", in_ready, wr_en);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    in_data  = 8'h41;
    @(negedge clk);
    tests++;
    if (wr_en !== 1'b1 || wr_row !== 5'd0 || wr_col !== 7'd0 || wr_data !== 8'h41 ||
        cursor_col !== 7'd1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_A: en=%0b row=%0d col=%0d data=%h ccol=%0d ready=%0b, required 1 0 0 41 1 1",
               wr_en, wr_row, wr_col, wr_data, cursor_col, in_ready);
    end
    in_data = 8'h42;
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (wr_en !== 1'b1 || wr_row !== 5'd0 || wr_col !== 7'd1 || wr_data !== 8'h42 ||
        cursor_col !== 7'd2 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_B: en=%0b row=%0d col=%0d data=%h ccol=%0d ready=%0b, required 1 0 1 42 2 1",
               wr_en, wr_row, wr_col, wr_data, cursor_col, in_ready);
    end
    @(negedge clk);
    tests++;
    if (wr_en !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: en=%0b, required 0", wr_en);
    end
  endtask

  task automatic test_line_wrap();
    int bad;
    logic [7:0] ch;
    send(8'h0D);
    tests++;
    if (cursor_col !== 7'd0 || wr_en !== 1'b0) begin
      fails++;
      $display("FAIL cr_home: ccol=%0d en=%0b, required 0 0", cursor_col, wr_en);
    end
    bad = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      ch      = 8'h30 + 8'(i % 10);
      in_data = ch;
      @(negedge clk);
      if (bad == 0 && (wr_en !== 1'b1 || wr_row !== 5'd0 || wr_col !== 7'(i) || wr_data !== ch)) begin
        bad = 1;
        $display("FAIL row0_fill: i=%0d en=%0b row=%0d col=%0d data=%h, required 1 0 %0d %h",
                 i, wr_en, wr_row, wr_col, wr_data, i, ch);
      end
    end
    in_valid = 1'b0;
    tests++;
    if (bad != 0) fails++;
    tests++;
    if (cursor_row !== 5'd1 || cursor_col !== 7'd0 || scroll_top !== 5'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL wrap_cursor: row=%0d col=%0d top=%0d ready=%0b, required 1 0 0 1",
               cursor_row, cursor_col, scroll_top, in_ready);
    end
    @(negedge clk);
    tests++;
    if (wr_en !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL wrap_noclear: en=%0b ready=%0b, required 0 1", wr_en, in_ready);
    end
  endtask

  task automatic test_lf_scroll();
    int writes;
    int bad;
    writes = 0;
    for (int i = 0; i < 22; i++) begin
      send(8'h0A);
      if (wr_en === 1'b1) writes++;
    end
    tests++;
    if (writes != 0 || cursor_row !== 5'd23 || cursor_col !== 7'd0 || scroll_top !== 5'd0) begin
      fails++;
      $display("FAIL lf_down: writes=%0d row=%0d col=%0d top=%0d, required 0 23 0 0",
               writes, cursor_row, cursor_col, scroll_top);
    end
    send(8'h0A);
    tests++;
    if (scroll_top !== 5'd1 || cursor_row !== 5'd23) begin
      fails++;
      $display("FAIL lf_scroll: top=%0d row=%0d, required 1 23", scroll_top, cursor_row);
    end
    bad = 0;
    for (int k = 1; k <= 80; k++) begin
      if (bad == 0 && (wr_en !== 1'b1 || in_ready !== 1'b0 || wr_row !== 5'd0 ||
                       wr_col !== 7'(k-1) || wr_data !== 8'h20)) begin
        bad = 1;
        $display("FAIL lf_clear: k=%0d en=%0b ready=%0b row=%0d col=%0d data=%h, required 1 0 0 %0d 20",
                 k, wr_en, in_ready, wr_row, wr_col, wr_data, k-1);
      end
      @(negedge clk);
    end
    tests++;
    if (bad != 0) fails++;
    tests++;
    if (in_ready !== 1'b1 || wr_en !== 1'b0) begin
      fails++;
      $display("FAIL lf_clear_end: ready=%0b en=%0b, required 1 0", in_ready, wr_en);
    end
  endtask

  task automatic test_scroll_wrap();
    int bad;
    for (int i = 0; i < 22; i++) send(8'h0A);
    tests++;
    if (scroll_top !== 5'd23) begin
      fails++;
      $display("FAIL top_23: top=%0d, required 23", scroll_top);
    end
    send(8'h0A);
    tests++;
    if (scroll_top !== 5'd0 || cursor_row !== 5'd23) begin
      fails++;
      $display("FAIL top_wrap: top=%0d row=%0d, required 0 23", scroll_top, cursor_row);
    end
    bad = 0;
    for (int k = 1; k <= 80; k++) begin
      if (bad == 0 && (wr_en !== 1'b1 || in_ready !== 1'b0 || wr_row !== 5'd23 || wr_col !== 7'(k-1))) begin
        bad = 1;
        $display("FAIL wrap_clear: k=%0d en=%0b ready=%0b row=%0d col=%0d, required 1 0 23 %0d",
                 k, wr_en, in_ready, wr_row, wr_col, k-1);
      end
      @(negedge clk);
    end
    tests++;
    if (bad != 0) fails++;
    send(8'h58);
    tests++;
    if (wr_en !== 1'b1 || wr_row !== 5'd23 || wr_col !== 7'd0 || wr_data !== 8'h58 || cursor_col !== 7'd1) begin
      fails++;
      $display("FAIL x_write: en=%0b row=%0d col=%0d data=%h ccol=%0d, required 1 23 0 58 1",
               wr_en, wr_row, wr_col, wr_data, cursor_col);
    end
  endtask

  task automatic test_end_scroll();
    int bad;
    for (int i = 0; i < 78; i++) send(8'h2E);
    tests++;
    if (cursor_col !== 7'd79 || cursor_row !== 5'd23) begin
      fails++;
      $display("FAIL pre_corner: row=%0d col=%0d, required 23 79", cursor_row, cursor_col);
    end
    send(8'h5A);
    tests++;
    if (wr_en !== 1'b1 || wr_row !== 5'd23 || wr_col !== 7'd79 || wr_data !== 8'h5A || in_ready !== 1'b0 ||
        scroll_top !== 5'd1 || cursor_row !== 5'd23 || cursor_col !== 7'd0) begin
      fails++;
      $display("FAIL corner_char: en=%0b row=%0d col=%0d data=%h ready=%0b top=%0d crow=%0d ccol=%0d, required 1 23 79 5a 0 1 23 0",
               wr_en, wr_row, wr_col, wr_data, in_ready, scroll_top, cursor_row, cursor_col);
    end
    bad = 0;
    for (int k = 2; k <= 81; k++) begin
      @(negedge clk);
      if (bad == 0 && (wr_en !== 1'b1 || in_ready !== 1'b0 || wr_row !== 5'd0 ||
                       wr_col !== 7'(k-2) || wr_data !== 8'h20)) begin
        bad = 1;
        $display("FAIL corner_clear: k=%0d en=%0b ready=%0b row=%0d col=%0d data=%h, required 1 0 0 %0d 20",
                 k, wr_en, in_ready, wr_row, wr_col, wr_data, k-2);
      end
    end
    tests++;
    if (bad != 0) fails++;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || wr_en !== 1'b0) begin
      fails++;
      $display("FAIL corner_end: ready=%0b en=%0b, required 1 0", in_ready, wr_en);
    end
  endtask

  task automatic test_controls();
    send(8'h08);
    tests++;
    if (cursor_col !== 7'd0 || wr_en !== 1'b0) begin
      fails++;
      $display("FAIL bs_col0: ccol=%0d en=%0b, required 0 0", cursor_col, wr_en);
    end
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
    tests++;
    if (wr_en !== 1'b1 || wr_row !== 5'd0 || wr_col !== 7'd4 || wr_data !== 8'h65 || cursor_col !== 7'd5) begin
      fails++;
      $display("FAIL phys_wrap: en=%0b row=%0d col=%0d data=%h ccol=%0d, required 1 0 4 65 5",
               wr_en, wr_row, wr_col, wr_data, cursor_col);
    end
    send(8'h08);
    tests++;
    if (cursor_col !== 7'd4 || wr_en !== 1'b0) begin
      fails++;
      $display("FAIL bs_dec: ccol=%0d en=%0b, required 4 0", cursor_col, wr_en);
    end
    send(8'h0D);
    tests++;
    if (cursor_col !== 7'd0 || wr_en !== 1'b0) begin
      fails++;
      $display("FAIL cr_col: ccol=%0d en=%0b, required 0 0", cursor_col, wr_en);
    end
    send(8'h07);
    tests++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd23 || wr_en !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL ignore_bel: col=%0d row=%0d en=%0b ready=%0b, required 0 23 0 1",
               cursor_col, cursor_row, wr_en, in_ready);
    end
  endtask

  task automatic test_reset_mid_clear();
    send(8'h0A);
    repeat (10) @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || wr_en !== 1'b1) begin
      fails++;
      $display("FAIL mid_clear: ready=%0b en=%0b, required 0 1", in_ready, wr_en);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (wr_en !== 1'b0 || wr_row !== 5'd0 || wr_col !== 7'd0 || wr_data !== 8'h20 || scroll_top !== 5'd0 ||
        cursor_row !== 5'd0 || cursor_col !== 7'd0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: en=%0b row=%0d col=%0d data=%h top=%0d crow=%0d ccol=%0d ready=%0b, required 0 0 0 20 0 0 0 0",
               wr_en, wr_row, wr_col, wr_data, scroll_top, cursor_row, cursor_col, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (wr_en !== 1'b1 || wr_row !== 5'd0 || wr_col !== 7'd1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL init_restart: en=%0b row=%0d col=%0d ready=%0b, required 1 0 1 0",
               wr_en, wr_row, wr_col, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_back_to_back();
    test_line_wrap();
    test_lf_scroll();
    test_scroll_wrap();
    test_end_scroll();
    test_controls();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
